axi_sram_slave: RTL

//  AXI3 responder that fronts a 32-bit synchronous single-port SRAM with 1-cycle read latency.

---
 rtl/axi_sram_slave_pkg.sv | 24 ++
 rtl/axi_sram_slave_if.sv | 56 +++++
 rtl/axi_sram_slave_addr_gen.sv | 19 +
 rtl/axi_sram_slave.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI encodings and the responder FSM state type.
package axi_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_WR_DATA,
        ST_WR_RESP
    } state_t;

    // The bus is 32 bits wide, so beat sizes above 4 bytes step by 4 bytes.
    function automatic logic [2:0] eff_size(input logic [2:0] size);
        return (size > 3'd2) ? 3'd2 : size;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between the interconnect and the SRAM responder.
interface axi_sram_slave_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );

endinterface

// File: rtl/axi_sram_slave_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts (WRAP steps like INCR).
module axi_burst_addr_gen
    import axi_sram_slave_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    // FIXED holds the address; any other burst type steps by the beat size, wrapping mod 2^32.
    always_comb begin
        next_addr = addr;
        if (burst != BURST_FIXED) begin
            next_addr = addr + (32'd1 << eff_size(size));
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 single-transaction responder in front of a 1-cycle-latency 32-bit SRAM.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_sram_slave_if.slave       bus,
    output logic                  ram_en,
    output logic [3:0]            ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    state_t              state;
    logic                prio_rd;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         addr_q;
    logic [31:0]         next_addr;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                wr_err_q;
    logic                rvalid_q;
    logic                rlast_q;
    logic                wready_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;

    logic                ar_grant;
    logic                aw_grant;
    logic                w_fire;
    logic                beat_last;
    logic                wlast_bad;
    logic                unused_wid;

    // One address register serves both directions since only one burst is ever in flight.
    axi_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Grant and SRAM strobes are combinational so a W beat reaches the SRAM in its handshake cycle.
    always_comb begin
        ar_grant  = (state == ST_IDLE) && bus.arvalid && (!bus.awvalid || prio_rd);
        aw_grant  = (state == ST_IDLE) && bus.awvalid && (!bus.arvalid || !prio_rd);
        w_fire    = (state == ST_WR_DATA) && wready_q && bus.wvalid;
        beat_last = (cnt_q == len_q);
        wlast_bad = (bus.wlast != beat_last);
        ram_en    = (state == ST_RD_REQ) || w_fire;
        ram_wen   = w_fire ? bus.wstrb : 4'b0000;
        ram_wdata = bus.wdata;
        ram_addr  = addr_q[ADDR_WIDTH+1:2];
    end

    assign bus.arready = ar_grant;
    assign bus.awready = aw_grant;
    assign bus.wready  = wready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = ram_rdata;
    assign bus.rid     = id_q;
    assign bus.rresp   = RESP_OKAY;
    assign bus.rlast   = rlast_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = id_q;
    assign bus.bresp   = bresp_q;
    assign unused_wid  = ^bus.wid;

    // Transaction FSM: one burst at a time, read beats alternate SRAM request and response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            prio_rd  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            wr_err_q <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_grant) begin
                        id_q    <= bus.arid;
                        addr_q  <= bus.araddr;
                        len_q   <= bus.arlen;
                        size_q  <= bus.arsize;
                        burst_q <= bus.arburst;
                        cnt_q   <= '0;
                        state   <= ST_RD_REQ;
                    end else if (aw_grant) begin
                        id_q     <= bus.awid;
                        addr_q   <= bus.awaddr;
                        len_q    <= bus.awlen;
                        size_q   <= bus.awsize;
                        burst_q  <= bus.awburst;
                        cnt_q    <= '0;
                        wr_err_q <= 1'b0;
                        wready_q <= 1'b1;
                        state    <= ST_WR_DATA;
                    end
                    // Priority only moves when both sides competed, so a lone request never steals the next turn.
                    if (bus.arvalid && bus.awvalid) begin
                        prio_rd <= !prio_rd;
                    end
                end
                ST_RD_REQ: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= beat_last;
                    state    <= ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    if (bus.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            state <= ST_IDLE;
                        end else begin
                            addr_q <= next_addr;
                            cnt_q  <= cnt_q + 8'd1;
                            state  <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_fire) begin
                        addr_q <= next_addr;
                        if (beat_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (wr_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            state    <= ST_WR_RESP;
                        end else begin
                            cnt_q    <= cnt_q + 8'd1;
                            wr_err_q <= wr_err_q || wlast_bad;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bus.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
